// File: rtl/lcd_sched_pkg.sv
// Shared types and constants for the LCD frame scheduler.
// Optional double-buffer build: define LCD_DBUF_EN.
package lcd_sched_pkg;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RET} state_t;

    localparam logic       HALF_L = 1'b0;
    localparam logic       HALF_R = 1'b1;
    localparam logic [2:0] X_LAST = 3'd7;
    localparam logic [5:0] Y_LAST = 6'd63;

    // Next half-panel position; bit 9 flags the wrap from the last byte of the frame.
    function automatic logic [9:0] step_pos(input logic [2:0] x, input logic [5:0] y);
        if (y == Y_LAST)
            return {x == X_LAST, x + 3'd1, 6'd0};
        else
            return {1'b0, x, y + 6'd1};
    endfunction

endpackage

// File: rtl/lcd_rr_arb.sv
// Two-way round-robin arbiter for the left/right LCD halves.
// On a tie the half not granted last wins; after reset the left half wins.
module lcd_rr_arb
    import lcd_sched_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic pend_l,
    input  logic pend_r,
    input  logic advance,
    output logic gnt,
    output logic gnt_half
);

    logic last_half;

    // advance marks a grant as taken, so the recorded half is the one served last
    always_ff @(posedge clk) begin
        if (rst)
            last_half <= HALF_R;
        else if (advance)
            last_half <= gnt_half;
    end

    always_comb begin
        gnt      = pend_l | pend_r;
        gnt_half = HALF_L;
        if (pend_l && pend_r)
            gnt_half = ~last_half;
        else if (pend_r)
            gnt_half = HALF_R;
    end

endmodule

// File: rtl/lcd_frame_scheduler.sv
// Shares one frame-buffer read port between the left and right LCD half-panel controllers.
// Define LCD_DBUF_EN for a second frame bank selected by swap_req at frame boundaries.
module lcd_frame_scheduler
    import lcd_sched_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int DV_HOLD = 2,
`ifdef LCD_DBUF_EN
    parameter int ADDR_W  = 11
`else
    parameter int ADDR_W  = 10
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              req_l,
    input  logic              req_r,
    output logic [7:0]        data_l,
    output logic              data_valid_l,
    output logic [7:0]        data_r,
    output logic              data_valid_r,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    input  logic              frame_start,
`ifdef LCD_DBUF_EN
    input  logic              swap_req,
`endif
    output logic              frame_done,
    output logic              busy
);

    localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);
    localparam logic [3:0] DV_LAST  = 4'(DV_HOLD - 1);

    state_t      state, state_nx;
    logic        owner;
    logic [3:0]  cnt;
    logic        pend_l, pend_r, eff_l, eff_r;
    logic        gnt, gnt_half, take, cap, ret_end, serve_l, serve_r;
    logic [2:0]  x_l, x_r, cur_x;
    logic [5:0]  y_l, y_r, cur_y;
    logic        done_l, done_r, both_done;
    logic [9:0]  step_l, step_r;
    logic [ADDR_W-1:0] rd_addr;
    logic        bank;

    // A request arriving with frame_start is discarded, not queued.
    assign eff_l = (pend_l | req_l) & ~frame_start;
    assign eff_r = (pend_r | req_r) & ~frame_start;

    lcd_rr_arb u_arb (
        .clk      (clk),
        .rst      (rst),
        .pend_l   (eff_l),
        .pend_r   (eff_r),
        .advance  (take),
        .gnt      (gnt),
        .gnt_half (gnt_half)
    );

    assign take      = (state == S_IDLE) && enable && gnt;
    assign cap       = (state == S_WAIT) && (cnt == LAT_LAST);
    assign ret_end   = (state == S_RET)  && (cnt == DV_LAST);
    assign serve_l   = ((state != S_IDLE) && (owner == HALF_L)) || (take && (gnt_half == HALF_L));
    assign serve_r   = ((state != S_IDLE) && (owner == HALF_R)) || (take && (gnt_half == HALF_R));
    assign both_done = done_l & done_r;
    assign step_l    = step_pos(x_l, y_l);
    assign step_r    = step_pos(x_r, y_r);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (take)    state_nx = S_ISSUE;
            S_ISSUE:              state_nx = S_WAIT;
            S_WAIT:  if (cap)     state_nx = S_RET;
            S_RET:   if (ret_end) state_nx = S_IDLE;
            default:              state_nx = S_IDLE;
        endcase
        if (frame_start)
            state_nx = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            owner <= HALF_L;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (take)
                owner <= gnt_half;
            cnt <= (state_nx != state) ? 4'd0 : cnt + 4'd1;
        end
    end

    // Requests for a half already in service merge into that service.
    always_ff @(posedge clk) begin
        if (rst || frame_start) begin
            pend_l <= 1'b0;
            pend_r <= 1'b0;
        end else begin
            pend_l <= (pend_l | req_l) & ~serve_l;
            pend_r <= (pend_r | req_r) & ~serve_r;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || frame_start) begin
            x_l <= '0; y_l <= '0; done_l <= 1'b0;
            x_r <= '0; y_r <= '0; done_r <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= both_done;
            if (both_done) begin
                done_l <= 1'b0;
                done_r <= 1'b0;
            end
            if (ret_end && owner == HALF_L) begin
                x_l <= step_l[8:6];
                y_l <= step_l[5:0];
                if (step_l[9]) done_l <= 1'b1;
            end
            if (ret_end && owner == HALF_R) begin
                x_r <= step_r[8:6];
                y_r <= step_r[5:0];
                if (step_r[9]) done_r <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_l <= '0;
            data_r <= '0;
        end else if (cap && !frame_start) begin
            if (owner == HALF_L) data_l <= mem_data;
            else                 data_r <= mem_data;
        end
    end

`ifdef LCD_DBUF_EN
    logic swap_seen;

    always_ff @(posedge clk) begin
        if (rst) begin
            bank      <= 1'b0;
            swap_seen <= 1'b0;
        end else if (both_done && !frame_start) begin
            bank      <= bank ^ (swap_seen | swap_req);
            swap_seen <= 1'b0;
        end else if (swap_req) begin
            swap_seen <= 1'b1;
        end
    end

    assign rd_addr = ADDR_W'({bank, owner, cur_x, cur_y});
`else
    assign bank    = 1'b0;
    assign rd_addr = ADDR_W'({bank, owner, cur_x, cur_y});
`endif

    assign cur_x        = (owner == HALF_R) ? x_r : x_l;
    assign cur_y        = (owner == HALF_R) ? y_r : y_l;
    assign mem_rd       = (state == S_ISSUE);
    assign mem_addr     = mem_rd ? rd_addr : '0;
    assign data_valid_l = (state == S_RET) && (owner == HALF_L);
    assign data_valid_r = (state == S_RET) && (owner == HALF_R);
    assign busy         = (state != S_IDLE);

endmodule
